// File: rtl/bldc_startup_sequencer.sv
// Startup sequencer for one BLDC controller: arm -> rotor align -> open-loop ramp -> closed-loop run.
// Duty changes are slew-limited and loss of zero-crossing activity drops the motor into FAULT.
module bldc_startup_sequencer #(
  parameter int DUTY_W       = 16,
  parameter int DUTY_MIN     = 10,
  parameter int DUTY_MAX     = 100,
  parameter int ALIGN_CYCLES = 1000,
  parameter int RAMP_DIV     = 100,
  parameter int RAMP_STEP    = 1,
  parameter int ZC_TIMEOUT   = 200000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic [DUTY_W-1:0] duty_cmd_i,
  input  logic [2:0]        zero_crossing_i,
  input  logic              fault_clr_i,
  output logic              start_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic [2:0]        state_o,
  output logic              running_o,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int ALIGN_W = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int ZC_W    = $clog2(ZC_TIMEOUT);

  localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [ZC_W-1:0]    ZC_LAST    = ZC_W'(ZC_TIMEOUT - 1);
  localparam logic [DUTY_W-1:0]  MIN_D      = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0]  MAX_D      = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]  STEP_D     = DUTY_W'(RAMP_STEP);

  state_t             r_state, w_state_next;
  logic [2:0]         r_zc_s1, r_zc_s2, r_zc_s3;
  logic [ALIGN_W-1:0] r_align_cnt, w_align_cnt_next;
  logic [DIV_W-1:0]   r_div_cnt, w_div_cnt_next;
  logic [ZC_W-1:0]    r_zc_timer, w_zc_timer_next;
  logic               r_zc_seen, w_zc_seen_next;
  logic               r_start, w_start_next;
  logic [DUTY_W-1:0]  r_duty, w_duty_next;
  logic               r_running, r_fault;

  logic               w_zc_edge, w_tick, w_timeout;
  logic [DUTY_W-1:0]  w_target, w_diff, w_slewed;

  assign w_zc_edge = |(r_zc_s2 ^ r_zc_s3);
  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_timeout = !w_zc_edge && (r_zc_timer == ZC_LAST);

  always_comb begin
    w_target = duty_cmd_i;
    if (duty_cmd_i < MIN_D) begin
      w_target = MIN_D;
    end else if (duty_cmd_i > MAX_D) begin
      w_target = MAX_D;
    end
  end

  // One slew step toward the target, landing exactly on it when closer than a full step.
  always_comb begin
    w_diff   = '0;
    w_slewed = r_duty;
    if (r_duty < w_target) begin
      w_diff   = w_target - r_duty;
      w_slewed = (w_diff > STEP_D) ? (r_duty + STEP_D) : w_target;
    end else if (r_duty > w_target) begin
      w_diff   = r_duty - w_target;
      w_slewed = (w_diff > STEP_D) ? (r_duty - STEP_D) : w_target;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_align_cnt_next = r_align_cnt;
    w_div_cnt_next   = r_div_cnt;
    w_zc_timer_next  = r_zc_timer;
    w_zc_seen_next   = r_zc_seen;
    w_start_next     = r_start;
    w_duty_next      = r_duty;

    unique case (r_state)
      S_IDLE: begin
        w_start_next = 1'b0;
        w_duty_next  = '0;
        if (arm_i) begin
          w_state_next     = S_ALIGN;
          w_start_next     = 1'b1;
          w_duty_next      = MIN_D;
          w_align_cnt_next = '0;
        end
      end
      S_ALIGN: begin
        if (!arm_i) begin
          w_state_next = S_IDLE;
          w_start_next = 1'b0;
          w_duty_next  = '0;
        end else if (r_align_cnt == ALIGN_LAST) begin
          w_state_next    = S_RAMP;
          w_div_cnt_next  = '0;
          w_zc_timer_next = '0;
          w_zc_seen_next  = 1'b0;
        end else begin
          w_align_cnt_next = r_align_cnt + 1'b1;
        end
      end
      S_RAMP, S_RUN: begin
        if (!arm_i) begin
          w_state_next = S_IDLE;
          w_start_next = 1'b0;
          w_duty_next  = '0;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
          w_start_next = 1'b0;
          w_duty_next  = '0;
        end else begin
          w_div_cnt_next  = w_tick ? '0 : (r_div_cnt + 1'b1);
          w_zc_timer_next = w_zc_edge ? '0 : (r_zc_timer + 1'b1);
          if (w_zc_edge) begin
            w_zc_seen_next = 1'b1;
          end
          if (w_tick) begin
            w_duty_next = w_slewed;
          end
          if (r_state == S_RAMP && r_duty == w_target && r_zc_seen) begin
            w_state_next = S_RUN;
          end
        end
      end
      S_FAULT: begin
        w_start_next = 1'b0;
        w_duty_next  = '0;
        if (fault_clr_i && !arm_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_start_next = 1'b0;
        w_duty_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_zc_s1     <= '0;
      r_zc_s2     <= '0;
      r_zc_s3     <= '0;
      r_align_cnt <= '0;
      r_div_cnt   <= '0;
      r_zc_timer  <= '0;
      r_zc_seen   <= 1'b0;
      r_start     <= 1'b0;
      r_duty      <= '0;
      r_running   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_zc_s1     <= zero_crossing_i;
      r_zc_s2     <= r_zc_s1;
      r_zc_s3     <= r_zc_s2;
      r_align_cnt <= w_align_cnt_next;
      r_div_cnt   <= w_div_cnt_next;
      r_zc_timer  <= w_zc_timer_next;
      r_zc_seen   <= w_zc_seen_next;
      r_start     <= w_start_next;
      r_duty      <= w_duty_next;
      r_running   <= (w_state_next == S_RUN);
      r_fault     <= (w_state_next == S_FAULT);
    end
  end

  assign start_o   = r_start;
  assign duty_o    = r_duty;
  assign state_o   = r_state;
  assign running_o = r_running;
  assign fault_o   = r_fault;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// Bench for bldc_startup_sequencer: directed scenarios plus a randomized phase, every cycle
// checked against an event-time reference model of the startup rules.
module tb_bldc_startup_sequencer;
  localparam int DUTY_W       = 16;
  localparam int DUTY_MIN     = 10;
  localparam int DUTY_MAX     = 100;
  localparam int ALIGN_CYCLES = 8;
  localparam int RAMP_DIV     = 4;
  localparam int RAMP_STEP    = 2;
  localparam int ZC_TIMEOUT   = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm = 1'b0;
  logic              fault_clr = 1'b0;
  logic [DUTY_W-1:0] duty_cmd = '0;
  logic [2:0]        zc = '0;
  logic              start_o;
  logic [DUTY_W-1:0] duty_o;
  logic [2:0]        state_o;
  logic              running_o;
  logic              fault_o;

  always #5 clk = ~clk;

  bldc_startup_sequencer #(
    .DUTY_W(DUTY_W), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .ALIGN_CYCLES(ALIGN_CYCLES), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP),
    .ZC_TIMEOUT(ZC_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .duty_cmd_i(duty_cmd),
    .zero_crossing_i(zc), .fault_clr_i(fault_clr),
    .start_o(start_o), .duty_o(duty_o), .state_o(state_o),
    .running_o(running_o), .fault_o(fault_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: state plus the clock numbers of the events that govern timing.
  int   m_state = 0;
  int   m_duty  = 0;
  bit   m_start = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_seen  = 1'b0;
  int   t_align = 0;
  int   t_ramp  = 0;
  int   t_zc    = 0;
  logic [2:0] h1 = '0, h2 = '0, h3 = '0;
  bit   zce, tick, old_seen;
  int   tgt, old_duty;

  function automatic int clamp_cmd(input int c);
    if (c < DUTY_MIN) return DUTY_MIN;
    if (c > DUTY_MAX) return DUTY_MAX;
    return c;
  endfunction

  function automatic int step_toward(input int d, input int t);
    int delta;
    delta = t - d;
    if (delta > RAMP_STEP) delta = RAMP_STEP;
    if (delta < -RAMP_STEP) delta = -RAMP_STEP;
    return d + delta;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    // A raw input change reaches the edge detector two clocks after it is sampled.
    zce = (h2 != h3);
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_state = 0; m_duty = 0; m_start = 1'b0; m_valid = 1'b1;
    end else begin
      h3 = h2; h2 = h1; h1 = zc;
      case (m_state)
        0: if (arm) begin
          m_state = 1; m_duty = DUTY_MIN; m_start = 1'b1; t_align = cyc;
        end
        1: if (!arm) begin
          m_state = 0; m_duty = 0; m_start = 1'b0;
        end else if (cyc - t_align == ALIGN_CYCLES) begin
          m_state = 2; t_ramp = cyc; t_zc = cyc; m_seen = 1'b0;
        end
        2, 3: if (!arm) begin
          m_state = 0; m_duty = 0; m_start = 1'b0;
        end else if (!zce && (cyc - t_zc == ZC_TIMEOUT)) begin
          m_state = 4; m_duty = 0; m_start = 1'b0;
        end else begin
          tick = ((cyc - t_ramp) % RAMP_DIV == 0);
          tgt = clamp_cmd(int'(duty_cmd));
          old_duty = m_duty;
          old_seen = m_seen;
          if (zce) begin
            t_zc = cyc; m_seen = 1'b1;
          end
          if (tick) m_duty = step_toward(m_duty, tgt);
          if (m_state == 2 && old_duty == tgt && old_seen) m_state = 3;
        end
        default: if (fault_clr && !arm) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      total = total + 1;
      if (state_o !== 3'(m_state) || start_o !== m_start || duty_o !== DUTY_W'(m_duty) ||
          running_o !== (m_state == 3) || fault_o !== (m_state == 4)) begin
        bad = bad + 1;
        $display("FAIL cycle_compare cyc=%0d state/start/duty/run/flt got %0d/%0b/%0d/%0b/%0b want %0d/%0b/%0d/%0b/%0b",
                 cyc, state_o, start_o, duty_o, running_o, fault_o,
                 m_state, m_start, m_duty, (m_state == 3), (m_state == 4));
      end
    end
  end

  // Zero-crossing generator: flips one random phase every zc_period clocks.
  bit zc_en = 1'b0;
  int zc_period = 10;
  int zc_cnt = 0;
  int last_toggle = 0;
  int zc_bit;
  always @(negedge clk) begin
    if (zc_en) begin
      zc_cnt = zc_cnt + 1;
      if (zc_cnt >= zc_period) begin
        zc_cnt = 0;
        zc_bit = int'($urandom_range(2, 0));
        zc[zc_bit] = ~zc[zc_bit];
        last_toggle = cyc;
      end
    end else begin
      zc_cnt = 0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state_o) != st && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    if (int'(state_o) != st) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s: no state %0d within %0d clks, state_o=%0d", name, st, budget, state_o);
    end
  endtask

  initial begin
    int n;
    int c0;
    rst = 1'b1; arm = 1'b1; duty_cmd = 16'd20;
    repeat (3) begin
      @(negedge clk);
      check("rst_state", int'(state_o), 0);
      check("rst_duty", int'(duty_o), 0);
      check("rst_start", int'(start_o), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("arm_state", int'(state_o), 1);
    check("arm_duty", int'(duty_o), 10);
    check("arm_start", int'(start_o), 1);
    check("model_arm_duty", m_duty, 10);

    // Align length and the first slew step of the ramp.
    zc_period = 10; zc_en = 1'b1;
    n = 0;
    while (int'(state_o) == 1 && n < 100) begin
      n = n + 1;
      @(negedge clk);
    end
    check("align_len", n, 8);
    check("ramp_state", int'(state_o), 2);
    check("ramp_d0", int'(duty_o), 10);
    repeat (3) @(negedge clk);
    check("ramp_d3", int'(duty_o), 10);
    @(negedge clk);
    check("ramp_d4", int'(duty_o), 12);
    check("model_ramp_d4", m_duty, 12);
    wait_state(3, 200, "reach_run");
    check("run_flag", int'(running_o), 1);
    check("run_duty", int'(duty_o), 20);

    // Clamp at both ends while running.
    duty_cmd = 16'($urandom_range(65535, 101));
    repeat (200) @(negedge clk);
    check("clamp_hi", int'(duty_o), 100);
    duty_cmd = 16'($urandom_range(9, 0));
    repeat (200) @(negedge clk);
    check("clamp_lo", int'(duty_o), 10);
    check("clamp_lo_state", int'(state_o), 3);

    // Stall: raw toggle -> sampled next clk -> edge 2 clks later -> FAULT 50 clks after that.
    zc_en = 1'b0;
    wait_state(4, 200, "reach_fault");
    check("fault_delay", cyc - last_toggle, 53);
    check("fault_start", int'(start_o), 0);
    check("fault_duty", int'(duty_o), 0);
    check("fault_flag", int'(fault_o), 1);
    arm = 1'b1; fault_clr = 1'b1;
    repeat (5) @(negedge clk);
    check("fault_sticky", int'(state_o), 4);
    arm = 1'b0;
    @(negedge clk);
    check("fault_cleared", int'(state_o), 0);
    fault_clr = 1'b0;

    // Disarm during ALIGN and during RAMP.
    duty_cmd = 16'd90; zc_en = 1'b1; arm = 1'b1;
    @(negedge clk);
    check("rearm_state", int'(state_o), 1);
    repeat ($urandom_range(6, 1)) @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("disarm_align", int'(state_o), 0);
    check("disarm_align_duty", int'(duty_o), 0);
    arm = 1'b1;
    wait_state(2, 50, "ramp_again");
    repeat ($urandom_range(3, 0)) @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("disarm_ramp", int'(state_o), 0);
    check("disarm_ramp_duty", int'(duty_o), 0);

    // Disarm on the very clock the stall timeout fires.
    zc_en = 1'b0;
    repeat (5) @(negedge clk);
    arm = 1'b1;
    wait_state(2, 50, "ramp_for_tmo");
    c0 = cyc;
    while (cyc < c0 + ZC_TIMEOUT - 1) @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("tmo_vs_disarm_state", int'(state_o), 0);
    check("tmo_vs_disarm_fault", int'(fault_o), 0);

    // Reset while running at duty 60, then a full re-align.
    duty_cmd = 16'd60; zc_en = 1'b1; arm = 1'b1;
    wait_state(3, 300, "run_60");
    check("run60_duty", int'(duty_o), 60);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", int'(state_o), 0);
    check("midrst_duty", int'(duty_o), 0);
    check("midrst_start", int'(start_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_state", int'(state_o), 1);
    n = 0;
    while (int'(state_o) == 1 && n < 100) begin
      n = n + 1;
      @(negedge clk);
    end
    check("postrst_align_len", n, 8);

    // Randomized phase, checked every cycle by the model.
    for (int it = 0; it < 40; it++) begin
      arm       = ($urandom_range(7, 0) != 0);
      fault_clr = ($urandom_range(3, 0) == 0);
      duty_cmd  = ($urandom_range(4, 0) == 0) ? 16'($urandom) : 16'($urandom_range(120, 0));
      zc_en     = ($urandom_range(3, 0) != 0);
      zc_period = int'($urandom_range(60, 2));
      rst       = ($urandom_range(14, 0) == 0);
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(150, 10)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
